freq_div_multi: RTL and testbench

//  Parametrised multi-channel frequency divider. Successor to the fixed /6 square and /5 pulse divider.

---
 rtl/freq_div_multi.sv | 86 ++++++++
 tb/tb_freq_div_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_multi.sv
// Multi-channel runtime-programmable clock divider: square or one-cycle pulse per channel, glitch-free divisor swap at wrap.
// Latency: outputs are registered one cycle behind the counter state; a new divisor takes effect after the current period.
// Backpressure: none; free-running strobe source, enable and sync are honoured every cycle.
module freq_div_multi #(
  parameter int CH          = 4,
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   mode,
  input  logic [CH*W-1:0] div,
  input  logic [CH-1:0]   load,
  input  logic            sync,
  output logic [CH-1:0]   div_out,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   pending
);

  localparam logic [W-1:0] DEF  = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] TWO  = W'(2);
  localparam logic [W-1:0] ZERO = '0;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] act;
    logic [W-1:0] shd;
    logic         pend;
    logic [W-1:0] div_i;
    logic [W-1:0] n_eff;
    logic [W-1:0] last;
    logic [W-1:0] hi_start;
    logic [W-1:0] act_nxt;
    logic         at_last;
    logic         dout_q;
    logic         tick_q;

    // Divisors 0 and 1 run as /2 so a channel can never stall.
    always_comb begin
      div_i    = div[i*W +: W];
      n_eff    = (act < TWO) ? TWO : act;
      last     = n_eff - ONE;
      hi_start = n_eff - (n_eff >> 1);
      at_last  = (cnt == last);
      act_nxt  = load[i] ? div_i : (pend ? shd : act);
    end

    // Every restart point (sync, idle, wrap) is a safe moment to swap divisors;
    // an idle channel sits at cnt 0, so promoting a stale shadow there is glitch-free.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt  <= ZERO;
        act  <= DEF;
        shd  <= ZERO;
        pend <= 1'b0;
      end else if (sync || !en[i] || at_last) begin
        cnt  <= ZERO;
        act  <= act_nxt;
        pend <= 1'b0;
      end else begin
        cnt <= cnt + ONE;
        if (load[i]) begin
          shd  <= div_i;
          pend <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= en[i] & at_last;
        dout_q <= en[i] & (mode[i] ? at_last : (cnt >= hi_start));
      end
    end

    assign div_out[i] = dout_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend;
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// Scoreboard bench for freq_div_multi: a cycle model predicts outputs, directed phases measure periods and patterns.
module tb_freq_div_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   en;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] div;
  logic [CH-1:0]   load;
  logic            sync;
  logic [CH-1:0]   div_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pending;

  freq_div_multi #(.CH(CH), .W(W), .DEFAULT_DIV(6)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
    .load(load), .sync(sync), .div_out(div_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] dout;
    logic [CH-1:0] tk;
    logic [CH-1:0] pnd;
  } exp_t;

  exp_t sb[$];
  int   m_cnt [CH];
  int   m_act [CH];
  int   m_shd [CH];
  bit   m_pend[CH];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff_n(input int a);
    return (a < 2) ? 2 : a;
  endfunction

  // Predict next outputs from the model, advance the model, then compare after the edge.
  task automatic step();
    exp_t e;
    int   n;
    int   dv;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      n  = eff_n(m_act[c]);
      dv = int'(div[c*W +: W]);
      if (!reset) begin
        e.tk[c]   = en[c] && (m_cnt[c] == n - 1);
        e.dout[c] = en[c] && (mode[c] ? (m_cnt[c] == n - 1) : (m_cnt[c] >= n - n / 2));
      end
      if (reset) begin
        m_cnt[c] = 0; m_act[c] = 6; m_shd[c] = 0; m_pend[c] = 0;
      end else if (sync || !en[c] || m_cnt[c] == n - 1) begin
        m_cnt[c] = 0;
        if (load[c])      m_act[c] = dv;
        else if (m_pend[c]) m_act[c] = m_shd[c];
        m_pend[c] = 0;
      end else begin
        m_cnt[c]++;
        if (load[c]) begin
          m_shd[c]  = dv;
          m_pend[c] = 1;
        end
      end
      e.pnd[c] = m_pend[c];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check_eq($sformatf("div_out@%0d", cyc), 32'(div_out), 32'(e.dout));
    check_eq($sformatf("tick@%0d", cyc),    32'(tick),    32'(e.tk));
    check_eq($sformatf("pending@%0d", cyc), 32'(pending), 32'(e.pnd));
  endtask

  task automatic wait_tick(input int c, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[c] && n < budget);
    check_eq($sformatf("tick_seen_ch%0d", c), 32'(tick[c]), 32'd1);
  endtask

  task automatic collect(input int c, input int len, output logic [7:0] pat);
    pat = '0;
    repeat (len) begin
      step();
      pat = {pat[6:0], div_out[c]};
    end
  endtask

  task automatic set_div(input int c, input int v);
    div[c*W +: W] = W'(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         n;
    logic [7:0] pat;
    int         first[CH];

    reset = 1'b1; en = '0; mode = '0; div = '0; load = '0; sync = 1'b0;
    step();
    step();
    check_eq("rst_div_out", 32'(div_out), 32'd0);
    check_eq("rst_tick",    32'(tick),    32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    reset = 1'b0;

    // Default /6 square on every channel.
    en = '1;
    wait_tick(0, 20, n); check_eq("t1_first_period", n, 6);
    wait_tick(0, 20, n); check_eq("t1_period", n, 6);
    collect(0, 6, pat);  check_eq("t1_square_pat", 32'(pat), 32'b000111);

    // Load /5 while idle, then run in pulse and square mode.
    en[1] = 1'b0;
    step();
    set_div(1, 5); load[1] = 1'b1;
    step();
    load = '0;
    check_eq("t2_idle_load_no_pend", 32'(pending[1]), 32'd0);
    step();
    en[1] = 1'b1; mode[1] = 1'b1;
    wait_tick(1, 20, n); check_eq("t2_en_latency", n, 5);
    collect(1, 5, pat);  check_eq("t2_pulse_pat", 32'(pat), 32'b00001);
    mode[1] = 1'b0;
    collect(1, 5, pat);  check_eq("t2_square5_pat", 32'(pat), 32'b00011);
    wait_tick(1, 20, n); check_eq("t2_period", n, 5);

    // Mid-period load on a /6 channel: old period completes, then /3.
    wait_tick(0, 20, n);
    step();
    step();
    set_div(0, 3); load[0] = 1'b1;
    step();
    load = '0;
    check_eq("t3_pending_set", 32'(pending[0]), 32'd1);
    wait_tick(0, 20, n); check_eq("t3_old_period", n + 3, 6);
    check_eq("t3_pending_clr", 32'(pending[0]), 32'd0);
    wait_tick(0, 20, n); check_eq("t3_new_period_a", n, 3);
    wait_tick(0, 20, n); check_eq("t3_new_period_b", n, 3);

    // Divisors 0 and 1 clamp to /2.
    set_div(2, 0); load[2] = 1'b1;
    step();
    load = '0;
    wait_tick(2, 20, n);
    wait_tick(2, 20, n);
    wait_tick(2, 20, n); check_eq("t4_div0_period", n, 2);
    collect(2, 4, pat);  check_eq("t4_toggle_pat", 32'(pat), 32'b0101);
    set_div(2, 1); load[2] = 1'b1;
    step();
    load = '0;
    wait_tick(2, 20, n);
    wait_tick(2, 20, n);
    wait_tick(2, 20, n); check_eq("t4_div1_period", n, 2);

    // Different divisors and phases, then a global sync.
    mode = '0;
    set_div(0, 4); set_div(1, 6); set_div(2, 7); load = 4'b0111;
    step();
    load = '0;
    repeat (20 + $urandom_range(0, 5)) step();
    set_div(3, 4); load[3] = 1'b1;
    step();
    load = '0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int c = 0; c < CH; c++) first[c] = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      for (int c = 0; c < CH; c++)
        if (first[c] == 0 && tick[c]) first[c] = k;
    end
    check_eq("t5_sync_ch0", first[0], 4);
    check_eq("t5_sync_ch1", first[1], 6);
    check_eq("t5_sync_ch2", first[2], 7);
    check_eq("t5_sync_ch3", first[3], 4);

    // Reset mid-period, then drop enable at cnt 3.
    repeat (2) step();
    reset = 1'b1;
    step();
    check_eq("t6_rst_div_out", 32'(div_out), 32'd0);
    check_eq("t6_rst_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    wait_tick(3, 20, n); check_eq("t6_default_period", n, 6);
    repeat (3) step();
    en[3] = 1'b0;
    step();
    check_eq("t6_en_drop_out",  32'(div_out[3]), 32'd0);
    check_eq("t6_en_drop_tick", 32'(tick[3]),    32'd0);
    repeat (3) step();
    en[3] = 1'b1;
    wait_tick(3, 20, n); check_eq("t6_restart_period", n, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
